// File: rtl/lcd_char_ctrl_if.sv
// lcd_char_ctrl_if: valid/ready request stream between user logic and the
// character LCD controller. The master owns valid/cmd/data and the
// controller (slave) owns ready.
interface lcd_char_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_cmd;
    logic [7:0] in_data;

    modport master (
        output in_valid,
        output in_cmd,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_cmd,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780-class character LCD controller, 8-bit parallel mode.
// Runs power-up delay and the init sequence (0x38, 0x0C, 0x06, 0x01), then
// accepts characters/commands on a valid/ready stream, generates E pulses
// from cycle-count parameters and tracks the cursor position.
// Optional feature macro: LCD_AUTOWRAP_EN -- when defined, a character that
// fills the last column triggers an internal set-address write (REPOS) to
// the start of the next line; when undefined the column saturates at COLS
// and further characters are swallowed without an E pulse.
module lcd_char_ctrl #(
    parameter int unsigned E_HIGH_CYC   = 50,
    parameter int unsigned E_LOW_CYC    = 50,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 80000,
    parameter int unsigned POWERUP_CYC  = 750000,
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    lcd_char_ctrl_if.slave            req,
    output logic [7:0]                lcd_data,
    output logic                      lcd_rs,
    output logic                      lcd_rw,
    output logic                      lcd_e,
    output logic                      init_done,
    output logic                      busy,
    output logic                      cur_row,
    output logic [$clog2(COLS+1)-1:0] cur_col
);

    localparam int unsigned     CW     = $clog2(COLS + 1);
    localparam logic [CW-1:0]   COLS_W = CW'(COLS);

    typedef enum logic [2:0] {
        S_PWRUP  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_SETUP  = 3'd3,
        S_EHIGH  = 3'd4,
        S_ELOW   = 3'd5,
        S_SETTLE = 3'd6
`ifdef LCD_AUTOWRAP_EN
        , S_REPOS = 3'd7
`endif
    } state_t;

    state_t          state_q;
    logic [31:0]     cnt_q;
    logic [1:0]      init_idx_q;
    logic [7:0]      lcd_data_q;
    logic            lcd_rs_q;
    logic            lcd_e_q;
    logic            init_done_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            cur_row_q;
    logic [CW-1:0]   cur_col_q;

    logic            wr_clr_s;
    logic            cur_row_d;
    logic [CW-1:0]   cur_col_d;
`ifdef LCD_AUTOWRAP_EN
    logic            wrap_s;
`else
    logic            drop_s;
`endif

    // Fixed init command table, indexed by the init step.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h06;
            default: c = 8'h01;
        endcase
        return c;
    endfunction

    // Cursor position that results from the write currently on the bus.
    always_comb begin
        wr_clr_s  = (lcd_rs_q == 1'b0) && (lcd_data_q >= 8'h01) && (lcd_data_q <= 8'h03);
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        if (lcd_rs_q) begin
            if (cur_col_q < COLS_W) begin
                cur_col_d = cur_col_q + CW'(1'b1);
            end else begin
                cur_col_d = cur_col_q;
            end
        end else if (wr_clr_s) begin
            cur_row_d = 1'b0;
            cur_col_d = {CW{1'b0}};
        end else if (lcd_data_q[7]) begin
            cur_row_d = lcd_data_q[6] && (ROWS == 32'd2);
            cur_col_d = CW'(lcd_data_q[5:0]);
        end else begin
            cur_row_d = cur_row_q;
            cur_col_d = cur_col_q;
        end
`ifdef LCD_AUTOWRAP_EN
        wrap_s = lcd_rs_q && (cur_col_d == COLS_W);
`else
        drop_s = (req.in_cmd == 1'b0) && (cur_col_q >= COLS_W);
`endif
    end

    // Main sequencer: power-up, init, request handling, E pulse timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= POWERUP_CYC - 32'd1;
            init_idx_q  <= 2'd0;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            cur_row_q   <= 1'b0;
            cur_col_q   <= {CW{1'b0}};
        end else begin
            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= S_INIT;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_INIT: begin
                    lcd_data_q <= init_cmd(init_idx_q);
                    lcd_rs_q   <= 1'b0;
                    cnt_q      <= 32'd0;
                    state_q    <= S_SETUP;
                end
                S_IDLE: begin
                    if (in_ready_q && req.in_valid) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= 32'd0;
`ifdef LCD_AUTOWRAP_EN
                        lcd_data_q <= req.in_data;
                        lcd_rs_q   <= ~req.in_cmd;
                        state_q    <= S_SETUP;
`else
                        // Line full: swallow the character, ready again next cycle.
                        if (drop_s) begin
                            state_q <= S_IDLE;
                        end else begin
                            lcd_data_q <= req.in_data;
                            lcd_rs_q   <= ~req.in_cmd;
                            state_q    <= S_SETUP;
                        end
`endif
                    end else begin
                        in_ready_q <= init_done_q;
                        busy_q     <= ~init_done_q;
                    end
                end
                S_SETUP: begin
                    lcd_e_q <= 1'b1;
                    cnt_q   <= E_HIGH_CYC - 32'd1;
                    state_q <= S_EHIGH;
                end
                S_EHIGH: begin
                    if (cnt_q == 32'd0) begin
                        lcd_e_q <= 1'b0;
                        cnt_q   <= E_LOW_CYC - 32'd1;
                        state_q <= S_ELOW;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_ELOW: begin
                    if (cnt_q == 32'd0) begin
                        cnt_q   <= wr_clr_s ? (CLR_WAIT_CYC - 32'd1) : (CMD_WAIT_CYC - 32'd1);
                        state_q <= S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 32'd0) begin
                        cur_row_q <= cur_row_d;
                        cur_col_q <= cur_col_d;
                        cnt_q     <= 32'd0;
                        if (!init_done_q) begin
                            if (init_idx_q == 2'd3) begin
                                init_done_q <= 1'b1;
                                cur_row_q   <= 1'b0;
                                cur_col_q   <= {CW{1'b0}};
                                in_ready_q  <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= S_IDLE;
                            end else begin
                                init_idx_q <= init_idx_q + 2'd1;
                                state_q    <= S_INIT;
                            end
`ifdef LCD_AUTOWRAP_EN
                        end else if (wrap_s) begin
                            state_q <= S_REPOS;
`endif
                        end else begin
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
`ifdef LCD_AUTOWRAP_EN
                S_REPOS: begin
                    // Set DDRAM address to the start of the following line.
                    lcd_data_q <= ((ROWS == 32'd2) && !cur_row_q) ? 8'hC0 : 8'h80;
                    lcd_rs_q   <= 1'b0;
                    cnt_q      <= 32'd0;
                    state_q    <= S_SETUP;
                end
`endif
                default: begin
                    lcd_e_q    <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    cnt_q      <= POWERUP_CYC - 32'd1;
                    state_q    <= S_PWRUP;
                end
            endcase
        end
    end

    assign req.in_ready = in_ready_q;
    assign lcd_data     = lcd_data_q;
    assign lcd_rs       = lcd_rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_e        = lcd_e_q;
    assign init_done    = init_done_q;
    assign busy         = busy_q;
    assign cur_row      = cur_row_q;
    assign cur_col      = cur_col_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: self-checking bench for lcd_char_ctrl with small timing
// parameters. Directed table of requests, hand sequences for init, back-to-back
// and mid-write reset, then random requests against a cursor/timing model.
module tb_lcd_char_ctrl;
    localparam int EH = 2, EL = 2, CMDW = 4, CLRW = 20, PWR = 10, NC = 4, NR = 2;
    localparam int OCC_CMD = 1 + EH + EL + CMDW;
    localparam int OCC_CLR = 1 + EH + EL + CLRW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, busy, cur_row;
    logic [2:0] cur_col;

    lcd_char_ctrl_if bus();

    lcd_char_ctrl #(
        .E_HIGH_CYC(EH), .E_LOW_CYC(EL), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW),
        .POWERUP_CYC(PWR), .COLS(NC), .ROWS(NR)
    ) dut (
        .clk(clk), .rst(rst), .req(bus),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .init_done(init_done), .busy(busy), .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // E pulse monitor: records data/rs at each rising edge and the high width.
    logic       e_prev = 1'b0;
    int         e_width = 0;
    logic [7:0] e_data_r = 8'h00;
    logic       e_rs_r = 1'b0;
    int         stab_err = 0;
    logic [7:0] pq_data[$];
    logic       pq_rs[$];
    int         pq_w[$];

    always @(negedge clk) begin
        e_prev <= lcd_e;
        if (lcd_e && !e_prev) begin
            pq_data.push_back(lcd_data);
            pq_rs.push_back(lcd_rs);
            e_data_r <= lcd_data;
            e_rs_r   <= lcd_rs;
            e_width  <= 1;
        end else if (lcd_e) begin
            e_width <= e_width + 1;
            if (lcd_data !== e_data_r || lcd_rs !== e_rs_r) stab_err <= stab_err + 1;
        end else if (e_prev) begin
            pq_w.push_back(e_width);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        pq_data.delete();
        pq_rs.delete();
        pq_w.delete();
    endtask

    // Reference cursor model.
    int m_row = 0;
    int m_col = 0;

    task automatic model_req(input bit cmd, input logic [7:0] d, output int e_lat,
                             output int e_np, output bit e_rs, output logic [7:0] e_data);
        int a;
        e_lat = OCC_CMD; e_np = 1; e_rs = !cmd; e_data = d;
        if (!cmd) begin
            if (m_col >= NC) begin
                e_lat = 1; e_np = 0; e_rs = 1'b0; e_data = 8'h00;
            end else begin
                m_col = m_col + 1;
`ifdef LCD_AUTOWRAP_EN
                if (m_col == NC) begin
                    m_row  = (NR == 2 && m_row == 0) ? 1 : 0;
                    m_col  = 0;
                    e_np   = 2;
                    e_rs   = 1'b0;
                    e_data = (m_row == 1) ? 8'hC0 : 8'h80;
                    e_lat  = 0;
                end
`endif
            end
        end else if (d >= 8'h01 && d <= 8'h03) begin
            m_row = 0; m_col = 0; e_lat = OCC_CLR;
        end else if (d >= 8'h80) begin
            a = int'(d) - 128;
            m_row = (a >= 64 && NR == 2) ? 1 : 0;
            m_col = a % 64;
        end
    endtask

    task automatic do_req(input bit cmd, input logic [7:0] d, output int lat, output int erise);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 1000) begin step(); guard++; end
        check("ready_before_req", bus.in_ready, 1);
        clear_pulses();
        bus.in_valid = 1'b1; bus.in_cmd = cmd; bus.in_data = d;
        step();
        bus.in_valid = 1'b0; bus.in_cmd = 1'($urandom); bus.in_data = 8'($urandom);
        check("ready_low_after_accept", bus.in_ready, 0);
        lat = 0; erise = -1;
        while (bus.in_ready !== 1'b1 && lat < 500) begin
            step(); lat++;
            if (erise < 0 && lcd_e === 1'b1) erise = lat;
        end
    endtask

    task automatic verify(input string tag, input bit cmd, input logic [7:0] d, input int lat,
                          input int erise, input int e_lat, input int e_np, input bit e_rs,
                          input logic [7:0] e_data, input int e_row, input int e_col);
        int wbad;
        if (e_lat > 0) check({tag, "_latency"}, lat, e_lat);
        else check({tag, "_wrap_latency_min"}, lat >= 2 * OCC_CMD, 1);
        check({tag, "_pulses"}, pq_data.size(), e_np);
        if (e_np > 0 && pq_data.size() == e_np) begin
            // lcd_e is high right after the edge that follows the accept edge.
            check({tag, "_e_rise"}, erise, 1);
            check({tag, "_first_data"}, pq_data[0], d);
            check({tag, "_first_rs"}, pq_rs[0], !cmd);
            check({tag, "_last_data"}, pq_data[e_np-1], e_data);
            check({tag, "_last_rs"}, pq_rs[e_np-1], e_rs);
        end
        wbad = 0;
        foreach (pq_w[i]) if (pq_w[i] != EH) wbad++;
        check({tag, "_e_width_bad"}, wbad, 0);
        check({tag, "_row"}, cur_row, e_row);
        check({tag, "_col"}, cur_col, e_col);
        check({tag, "_busy"}, busy, !bus.in_ready);
    endtask

    task automatic run_init_check();
        int cyc, first_rise, last_e;
        logic [7:0] init_exp[4];
        init_exp = '{8'h38, 8'h0C, 8'h06, 8'h01};
        rst = 1'b1;
        step(); step();
        clear_pulses();
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_cur_col", cur_col, 0);
        rst = 1'b0;
        cyc = 0; first_rise = -1; last_e = -1;
        while (init_done !== 1'b1 && cyc < 2000) begin
            step(); cyc++;
            if (lcd_e === 1'b1) begin
                last_e = cyc;
                if (first_rise < 0) first_rise = cyc;
            end
        end
        check("init_done_rise", init_done, 1);
        check("pwrup_quiet", first_rise > PWR, 1);
        check("init_pulses", pq_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pq_data.size()) begin
                check($sformatf("init_data%0d", i), pq_data[i], init_exp[i]);
                check($sformatf("init_rs%0d", i), pq_rs[i], 0);
            end
        end
        check("init_done_after_clr_settle", cyc - last_e, EL + CLRW + 1);
        check("init_ready", bus.in_ready, 1);
        check("init_busy", busy, 0);
        check("init_row", cur_row, 0);
        check("init_col", cur_col, 0);
        m_row = 0; m_col = 0;
    endtask

    typedef struct {
        bit         cmd;
        logic [7:0] data;
        int         row;
        int         col;
        int         lat;
        int         np;
        bit         last_rs;
        logic [7:0] last_data;
    } vec_t;

    vec_t vt[14];

    initial begin
        int lat, erise, e_lat, e_np, k, guard;
        bit e_rs, cmd, prev_ready;
        logic [7:0] e_data, d;

        vt[0]  = '{1'b0, 8'h41, 0, 1, OCC_CMD, 1, 1'b1, 8'h41};
        vt[1]  = '{1'b0, 8'h42, 0, 2, OCC_CMD, 1, 1'b1, 8'h42};
        vt[2]  = '{1'b1, 8'h01, 0, 0, OCC_CLR, 1, 1'b0, 8'h01};
        vt[3]  = '{1'b1, 8'hC2, 1, 2, OCC_CMD, 1, 1'b0, 8'hC2};
        vt[4]  = '{1'b1, 8'h0F, 1, 2, OCC_CMD, 1, 1'b0, 8'h0F};
        vt[5]  = '{1'b1, 8'h80, 0, 0, OCC_CMD, 1, 1'b0, 8'h80};
        vt[6]  = '{1'b0, 8'h61, 0, 1, OCC_CMD, 1, 1'b1, 8'h61};
        vt[7]  = '{1'b0, 8'h62, 0, 2, OCC_CMD, 1, 1'b1, 8'h62};
        vt[8]  = '{1'b0, 8'h63, 0, 3, OCC_CMD, 1, 1'b1, 8'h63};
`ifdef LCD_AUTOWRAP_EN
        vt[9]  = '{1'b0, 8'h64, 1, 0, 0,       2, 1'b0, 8'hC0};
        vt[10] = '{1'b0, 8'h65, 1, 1, OCC_CMD, 1, 1'b1, 8'h65};
        vt[11] = '{1'b0, 8'h66, 1, 2, OCC_CMD, 1, 1'b1, 8'h66};
        vt[12] = '{1'b0, 8'h67, 1, 3, OCC_CMD, 1, 1'b1, 8'h67};
        vt[13] = '{1'b0, 8'h68, 0, 0, 0,       2, 1'b0, 8'h80};
`else
        vt[9]  = '{1'b0, 8'h64, 0, 4, OCC_CMD, 1, 1'b1, 8'h64};
        vt[10] = '{1'b0, 8'h65, 0, 4, 1,       0, 1'b0, 8'h00};
        vt[11] = '{1'b1, 8'h02, 0, 0, OCC_CLR, 1, 1'b0, 8'h02};
        vt[12] = '{1'b1, 8'hC4, 1, 4, OCC_CMD, 1, 1'b0, 8'hC4};
        vt[13] = '{1'b0, 8'h68, 1, 4, 1,       0, 1'b0, 8'h00};
`endif

        bus.in_valid = 1'b0; bus.in_cmd = 1'b0; bus.in_data = 8'h00;

        run_init_check();

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            do_req(vt[i].cmd, vt[i].data, lat, erise);
            verify($sformatf("vec%0d", i), vt[i].cmd, vt[i].data, lat, erise, vt[i].lat,
                   vt[i].np, vt[i].last_rs, vt[i].last_data, vt[i].row, vt[i].col);
        end
        m_row = vt[13].row; m_col = vt[13].col;

        // Clear, then two characters with in_valid held high throughout.
        model_req(1'b1, 8'h01, e_lat, e_np, e_rs, e_data);
        do_req(1'b1, 8'h01, lat, erise);
        verify("clr", 1'b1, 8'h01, lat, erise, e_lat, e_np, e_rs, e_data, m_row, m_col);
        clear_pulses();
        bus.in_valid = 1'b1; bus.in_cmd = 1'b0; bus.in_data = 8'h58;
        step();
        check("b2b_ready_low", bus.in_ready, 0);
        k = 0; prev_ready = 1'b0;
        while (k < 100) begin
            step(); k++;
            if (prev_ready && bus.in_ready === 1'b0) break;
            prev_ready = bus.in_ready;
        end
        bus.in_valid = 1'b0;
        check("b2b_spacing", k, OCC_CMD + 1);
        check("b2b_pulses_between", pq_data.size(), 1);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin step(); guard++; end
        check("b2b_pulses_total", pq_data.size(), 2);
        model_req(1'b0, 8'h58, e_lat, e_np, e_rs, e_data);
        model_req(1'b0, 8'h58, e_lat, e_np, e_rs, e_data);
        check("b2b_col", cur_col, m_col);

        // Random requests against the model.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                cmd = 1'b0; d = 8'($urandom_range(32'h20, 32'h7E));
            end else if (r < 7) begin
                cmd = 1'b1;
                d = 8'h80 | (($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00) | 8'($urandom_range(0, NC - 1));
            end else if (r < 8) begin
                cmd = 1'b1; d = 8'($urandom_range(1, 3));
            end else begin
                cmd = 1'b1; d = 8'($urandom_range(4, 127));
            end
            model_req(cmd, d, e_lat, e_np, e_rs, e_data);
            do_req(cmd, d, lat, erise);
            verify($sformatf("rnd%0d", n), cmd, d, lat, erise, e_lat, e_np, e_rs, e_data, m_row, m_col);
        end

        // Reset asserted while lcd_e is high.
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 1000) begin step(); guard++; end
        bus.in_valid = 1'b1; bus.in_cmd = 1'b0; bus.in_data = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        guard = 0;
        while (lcd_e !== 1'b1 && guard < 20) begin step(); guard++; end
        check("e_high_before_reset", lcd_e, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lcd_e", lcd_e, 0);
        check("async_rst_init_done", init_done, 0);
        check("async_rst_ready", bus.in_ready, 0);
        check("async_rst_busy", busy, 1);
        run_init_check();
        model_req(1'b0, 8'h41, e_lat, e_np, e_rs, e_data);
        do_req(1'b0, 8'h41, lat, erise);
        verify("post_rst", 1'b0, 8'h41, lat, erise, e_lat, e_np, e_rs, e_data, m_row, m_col);

        check("data_stable_during_e", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
